vga_frame_capture: RTL and testbench
====================================

# vga_frame_capture

Receive-side counterpart of the VGA timing controller. The block monitors a 640x480@800x525 VGA stream (sync, blank and 10-bit DAC colour), locks to its timing, and turns each active dot back into a video-memory write. It downsamples to 320x240 or 160x120 and compresses colour to BITS_PER_COLOUR_CHANNEL. It sits in loopback test harnesses and frame-grab paths and feeds a video-memory write port.

## Interface
- BITS_PER_COLOUR_CHANNEL, 1, bits kept per colour channel (top bits of each 10-bit input).
- RESOLUTION, "320x240", "320x240" or "160x120"; sets downsample factor 2 or 4.
- C_HORZ_NUM_PIXELS, 10'd640, expected active columns per line.
- C_VERT_NUM_PIXELS, 10'd480, expected active lines per frame.
- C_HORZ_TOTAL_COUNT, 10'd800, expected cycles between HS falling edges.
- C_VERT_TOTAL_COUNT, 10'd525, expected HS falling edges between VS falling edges.
- Clock and reset (already decided): clock vga_clock; reset resetn, asynchronous, active-low.
- vga_clock  in  1  pixel clock, one input sample per edge.
- resetn  in  1  async active-low reset.
- VGA_R, VGA_G, VGA_B  in  10 each  DAC colour.
- VGA_HS, VGA_VS  in  1 each  sync, active low.
- VGA_BLANK  in  1  1 = active pixel.
- wr_address  out  17 (320x240) / 15 (160x120)  video-memory address, y*W + x.
- wr_colour  out  3*BITS_PER_COLOUR_CHANNEL  {R,G,B}, R in MSBs.
- wr_en  out  1  one-cycle write strobe per dot.
- locked  out  1  timing verified; writes enabled.
- sync_error  out  1  one-cycle pulse on timing violation.
- frame_done  out  1  one-cycle pulse at VS falling edge while locked.
- h_total, v_total  out  10 each  last measured line period and lines per frame, saturating at 1023.

## Operation
- Stage 1 registers all inputs. Edge detection compares stage 1 against its previous value.
- Line period: a counter runs from each HS fall. At the next HS fall it is latched into h_total and cleared.
- Frame length: a line counter counts HS falls. At each VS fall it is latched into v_total and cleared.
- Active column col: increments while BLANK=1 and clears when BLANK rises. Active row row: increments on each BLANK fall and clears on VS fall.
- Downsample by discarding low bits:
  - 320x240: x=col[9:1], y=row[8:1]; a dot is written only when col[0]=0 and row[0]=0.
  - 160x120: uses [9:2]/[8:2] with the low 2 bits equal to 0.
- Write guard: no write when col>=C_HORZ_NUM_PIXELS or row>=C_VERT_NUM_PIXELS.
- Address: y*320+x = (y<<8)+(y<<6)+x; y*160+x = (y<<7)+(y<<5)+x. Arithmetic is unsigned at full address width.
- Colour: wr_colour = {R[9:10-B], G[9:10-B], B[9:10-B]}.
- FSM states: SEARCH, MEASURE, LOCKED.
  - SEARCH → MEASURE on the first VS fall.
  - MEASURE → LOCKED at the next VS fall if all four checks pass: every line period = C_HORZ_TOTAL_COUNT, v_total = C_VERT_TOTAL_COUNT, active rows = C_VERT_NUM_PIXELS, and every active line has C_HORZ_NUM_PIXELS cols. Otherwise it stays in MEASURE, clears the check flags and re-measures.
  - LOCKED → MEASURE on any failed check. Line checks are evaluated at each HS fall; frame checks at each VS fall. The failure pulses sync_error and deasserts locked in the same cycle.
- wr_en is asserted only in LOCKED. frame_done pulses at each VS fall that keeps the FSM in LOCKED.
- Simultaneous HS and VS fall: the line closes first, then the frame check includes that line.
- A VS fall while BLANK=1 is a violation.
- Reset, at any time including mid-frame: all outputs go to 0 asynchronously, FSM → SEARCH, counters → 0. No write occurs until the FSM relocks after one full clean frame.

## Timing
- Reset values: wr_address=0, wr_colour=0, wr_en=0, locked=0, sync_error=0, frame_done=0, h_total=0, v_total=0.
- Latency: input sample at edge N → wr_en/wr_address/wr_colour registered valid after edge N+2.
- Write throughput: at most one write every 2 cycles (320x240) or every 4 cycles (160x120).
- locked, sync_error and frame_done are registered and change 2 edges after the offending or qualifying sync edge is sampled.
- Lock time from reset with clean timing: first VS fall plus one full frame (≤2 frames).

## Test plan
- Reset, then clean 800x525 timing → locked rises at the 2nd VS fall; h_total=800, v_total=525; sync_error stays 0.
- Locked, pixel (0,0) with R=3FF, G=000, B=3FF → wr_address=0, wr_colour=3'b101. Pixel (2,2) → 321. Pixel (638,478) → 76799. Pixels (639,x) and (x,479) produce no write.
- One full locked frame → exactly 76800 wr_en pulses and one frame_done pulse.
- One line stretched to 801 cycles → h_total=801, one sync_error pulse, locked=0, no writes; relock after the next clean full frame.
- resetn asserted mid-line while locked → all outputs 0 immediately; no wr_en until relock.
- RESOLUTION="160x120", pixel (4,4) → wr_address=161; 19200 writes per frame.

Source files
------------

// File: rtl/vga_frame_capture.sv
// Receive-side VGA monitor: locks to an 800x525-style sync stream, verifies its
// geometry, and turns each downsampled active dot into a video-memory write.
module vga_frame_capture #(
  parameter int         BITS_PER_COLOUR_CHANNEL = 1,
  parameter             RESOLUTION              = "320x240",
  parameter logic [9:0] C_HORZ_NUM_PIXELS       = 10'd640,
  parameter logic [9:0] C_VERT_NUM_PIXELS       = 10'd480,
  parameter logic [9:0] C_HORZ_TOTAL_COUNT      = 10'd800,
  parameter logic [9:0] C_VERT_TOTAL_COUNT      = 10'd525,
  localparam int        DS_SHIFT = (RESOLUTION == "160x120") ? 2 : 1,
  localparam int        AW       = (RESOLUTION == "160x120") ? 15 : 17,
  localparam int        CW       = 3 * BITS_PER_COLOUR_CHANNEL
) (
  input  logic          vga_clock,
  input  logic          resetn,
  input  logic [9:0]    VGA_R,
  input  logic [9:0]    VGA_G,
  input  logic [9:0]    VGA_B,
  input  logic          VGA_HS,
  input  logic          VGA_VS,
  input  logic          VGA_BLANK,
  output logic [AW-1:0] wr_address,
  output logic [CW-1:0] wr_colour,
  output logic          wr_en,
  output logic          locked,
  output logic          sync_error,
  output logic          frame_done,
  output logic [9:0]    h_total,
  output logic [9:0]    v_total
);

  localparam int         B        = BITS_PER_COLOUR_CHANNEL;
  localparam logic [9:0] LOW_MASK = 10'((1 << DS_SHIFT) - 1);
  // y*W expressed as two shifted copies: W=320 -> 256+64, W=160 -> 128+32.
  localparam int         A_HI     = (DS_SHIFT == 2) ? 7 : 8;
  localparam int         A_LO     = (DS_SHIFT == 2) ? 5 : 6;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state_q, state_d;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic [9:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, blank_prev_q, blank_prev_d;
  logic [9:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d, col_q, col_d, row_q, row_d;
  logic [9:0]    h_total_q, h_total_d, v_total_q, v_total_d;
  logic          cols_bad_q, cols_bad_d, armed_q, armed_d, meas_bad_q, meas_bad_d;
  logic          err_q, err_d, fd_q, fd_d;
  logic          pix_en_q, pix_en_d;
  logic [8:0]    pix_x_q, pix_x_d;
  logic [7:0]    pix_y_q, pix_y_d;
  logic [CW-1:0] pix_colour_q, pix_colour_d;
  logic          wr_en_q, wr_en_d, locked_q, locked_d, sync_error_q, sync_error_d;
  logic          frame_done_q, frame_done_d;
  logic [AW-1:0] wr_address_q, wr_address_d;
  logic [CW-1:0] wr_colour_q, wr_colour_d;

  logic          hs_fall, vs_fall, blank_rise, blank_fall;
  logic [9:0]    vcnt_plus, col_cur, rows_now;
  logic          cols_bad_now, line_fail, frame_bad;
  logic [AW-1:0] y_ext, x_ext;
  logic          unused_colour_lsbs;

  assign hs_fall    = hs_prev_q & ~hs_q;
  assign vs_fall    = vs_prev_q & ~vs_q;
  assign blank_rise = ~blank_prev_q & blank_q;
  assign blank_fall = blank_prev_q & ~blank_q;
  assign unused_colour_lsbs = ^{r_q, g_q, b_q};

  always_comb begin
    r_d          = VGA_R;
    g_d          = VGA_G;
    b_d          = VGA_B;
    hs_d         = VGA_HS;
    vs_d         = VGA_VS;
    blank_d      = VGA_BLANK;
    hs_prev_d    = hs_q;
    vs_prev_d    = vs_q;
    blank_prev_d = blank_q;
  end

  // Timing measurement: line period, lines per frame, active columns and rows.
  always_comb begin
    hcnt_d       = hs_fall ? 10'd1 : sat_inc(hcnt_q);
    h_total_d    = hs_fall ? hcnt_q : h_total_q;
    vcnt_plus    = hs_fall ? sat_inc(vcnt_q) : vcnt_q;
    vcnt_d       = vs_fall ? 10'd0 : vcnt_plus;
    v_total_d    = vs_fall ? vcnt_plus : v_total_q;
    col_cur      = blank_rise ? 10'd0 : col_q;
    col_d        = blank_q ? sat_inc(col_cur) : col_q;
    rows_now     = blank_fall ? sat_inc(row_q) : row_q;
    row_d        = vs_fall ? 10'd0 : rows_now;
    cols_bad_now = blank_fall && (col_q != C_HORZ_NUM_PIXELS);
    cols_bad_d   = hs_fall ? 1'b0 : (cols_bad_q | cols_bad_now);
    line_fail    = hs_fall && ((hcnt_q != C_HORZ_TOTAL_COUNT) || cols_bad_q || cols_bad_now);
    frame_bad    = (vcnt_plus != C_VERT_TOTAL_COUNT) || (rows_now != C_VERT_NUM_PIXELS) || blank_q;
  end

  // armed marks a measurement window that began at a VS fall, so a frame
  // interrupted by a failure never qualifies for lock.
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    meas_bad_d = meas_bad_q;
    err_d      = 1'b0;
    fd_d       = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d    = MEASURE;
          armed_d    = 1'b1;
          meas_bad_d = 1'b0;
        end
      end
      MEASURE: begin
        if (vs_fall) begin
          if (armed_q && !meas_bad_q && !line_fail && !frame_bad) begin
            state_d = LOCKED;
          end else begin
            armed_d    = 1'b1;
            meas_bad_d = 1'b0;
          end
        end else if (line_fail) begin
          meas_bad_d = 1'b1;
        end
      end
      LOCKED: begin
        if (line_fail || (vs_fall && frame_bad)) begin
          state_d    = MEASURE;
          err_d      = 1'b1;
          armed_d    = vs_fall;
          meas_bad_d = 1'b0;
        end else if (vs_fall) begin
          fd_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    pix_en_d = (state_q == LOCKED) && blank_q &&
               (col_cur < C_HORZ_NUM_PIXELS) && (row_q < C_VERT_NUM_PIXELS) &&
               ((col_cur & LOW_MASK) == 10'd0) && ((row_q & LOW_MASK) == 10'd0);
    pix_x_d      = 9'(col_cur >> DS_SHIFT);
    pix_y_d      = 8'(row_q >> DS_SHIFT);
    pix_colour_d = {r_q[9 -: B], g_q[9 -: B], b_q[9 -: B]};
  end

  always_comb begin
    y_ext        = AW'(pix_y_q);
    x_ext        = AW'(pix_x_q);
    wr_address_d = (y_ext << A_HI) + (y_ext << A_LO) + x_ext;
    wr_colour_d  = pix_colour_q;
    wr_en_d      = pix_en_q;
    locked_d     = (state_q == LOCKED);
    sync_error_d = err_q;
    frame_done_d = fd_q;
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      r_q <= '0; g_q <= '0; b_q <= '0;
      hs_q <= 1'b0; vs_q <= 1'b0; blank_q <= 1'b0;
      hs_prev_q <= 1'b0; vs_prev_q <= 1'b0; blank_prev_q <= 1'b0;
      hcnt_q <= '0; vcnt_q <= '0; col_q <= '0; row_q <= '0;
      h_total_q <= '0; v_total_q <= '0;
      cols_bad_q <= 1'b0; armed_q <= 1'b0; meas_bad_q <= 1'b0;
      err_q <= 1'b0; fd_q <= 1'b0;
      pix_en_q <= 1'b0; pix_x_q <= '0; pix_y_q <= '0; pix_colour_q <= '0;
      wr_en_q <= 1'b0; wr_address_q <= '0; wr_colour_q <= '0;
      locked_q <= 1'b0; sync_error_q <= 1'b0; frame_done_q <= 1'b0;
    end else begin
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
      hs_q <= hs_d; vs_q <= vs_d; blank_q <= blank_d;
      hs_prev_q <= hs_prev_d; vs_prev_q <= vs_prev_d; blank_prev_q <= blank_prev_d;
      hcnt_q <= hcnt_d; vcnt_q <= vcnt_d; col_q <= col_d; row_q <= row_d;
      h_total_q <= h_total_d; v_total_q <= v_total_d;
      cols_bad_q <= cols_bad_d; armed_q <= armed_d; meas_bad_q <= meas_bad_d;
      err_q <= err_d; fd_q <= fd_d;
      pix_en_q <= pix_en_d; pix_x_q <= pix_x_d; pix_y_q <= pix_y_d; pix_colour_q <= pix_colour_d;
      wr_en_q <= wr_en_d; wr_address_q <= wr_address_d; wr_colour_q <= wr_colour_d;
      locked_q <= locked_d; sync_error_q <= sync_error_d; frame_done_q <= frame_done_d;
    end
  end

  assign wr_address = wr_address_q;
  assign wr_colour  = wr_colour_q;
  assign wr_en      = wr_en_q;
  assign locked     = locked_q;
  assign sync_error = sync_error_q;
  assign frame_done = frame_done_q;
  assign h_total    = h_total_q;
  assign v_total    = v_total_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture using a reduced 24x12 raster (16x8 active)
// so whole frames stay short; one instance per resolution shares the stimulus.
module tb_vga_frame_capture;

  localparam int H_TOT = 24;
  localparam int H_ACT = 16;
  localparam int V_TOT = 12;
  localparam int V_ACT = 8;

  logic        vga_clock = 1'b0;
  logic        resetn    = 1'b0;
  logic [9:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
  logic        VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_BLANK = 1'b0;

  logic [16:0] a_wr_address;
  logic [2:0]  a_wr_colour;
  logic        a_wr_en, a_locked, a_sync_error, a_frame_done;
  logic [9:0]  a_h_total, a_v_total;
  logic [14:0] b_wr_address;
  logic [2:0]  b_wr_colour;
  logic        b_wr_en, b_locked, b_sync_error, b_frame_done;
  logic [9:0]  b_h_total, b_v_total;

  always #5 vga_clock = ~vga_clock;

  vga_frame_capture #(
    .BITS_PER_COLOUR_CHANNEL(1), .RESOLUTION("320x240"),
    .C_HORZ_NUM_PIXELS(10'd16), .C_VERT_NUM_PIXELS(10'd8),
    .C_HORZ_TOTAL_COUNT(10'd24), .C_VERT_TOTAL_COUNT(10'd12)
  ) dut_a (
    .vga_clock(vga_clock), .resetn(resetn),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
    .wr_address(a_wr_address), .wr_colour(a_wr_colour), .wr_en(a_wr_en),
    .locked(a_locked), .sync_error(a_sync_error), .frame_done(a_frame_done),
    .h_total(a_h_total), .v_total(a_v_total)
  );

  vga_frame_capture #(
    .BITS_PER_COLOUR_CHANNEL(1), .RESOLUTION("160x120"),
    .C_HORZ_NUM_PIXELS(10'd16), .C_VERT_NUM_PIXELS(10'd8),
    .C_HORZ_TOTAL_COUNT(10'd24), .C_VERT_TOTAL_COUNT(10'd12)
  ) dut_b (
    .vga_clock(vga_clock), .resetn(resetn),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
    .wr_address(b_wr_address), .wr_colour(b_wr_colour), .wr_en(b_wr_en),
    .locked(b_locked), .sync_error(b_sync_error), .frame_done(b_frame_done),
    .h_total(b_h_total), .v_total(b_v_total)
  );

  int total = 0;
  int bad   = 0;

  // Write logs and pulse counters, sampled away from the active edge.
  int          a_wr_total = 0, b_wr_total = 0, a_fd = 0, a_err = 0;
  logic [16:0] a_addr_log [0:1023];
  logic [2:0]  a_col_log  [0:1023];
  logic [14:0] b_addr_log [0:1023];

  always @(negedge vga_clock) begin
    if (a_wr_en && a_wr_total < 1024) begin
      a_addr_log[a_wr_total] <= a_wr_address;
      a_col_log[a_wr_total]  <= a_wr_colour;
      a_wr_total             <= a_wr_total + 1;
    end
    if (b_wr_en && b_wr_total < 1024) begin
      b_addr_log[b_wr_total] <= b_wr_address;
      b_wr_total             <= b_wr_total + 1;
    end
    if (a_frame_done) a_fd  <= a_fd + 1;
    if (a_sync_error) a_err <= a_err + 1;
  end

  logic [31:0] s_addr, s_col, s_en, s_lock, s_err, s_fd, s_ht, s_vt, s_b_en, s_b_lock, pre_lock;
  int base_a, base_b, base_fd, base_err, rst_base_a, rst_base_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_colour(input int h, input int v);
    return {~h[1], v[1], ~h[2]};
  endfunction

  // One raster frame: VS low on line 9, HS low for h in [18,21).
  task automatic drive_frame(input int stretch_v, input int rst_v, input int rst_h);
    for (int v = 0; v < V_TOT; v++) begin
      int hlen;
      hlen = (v == stretch_v) ? H_TOT + 1 : H_TOT;
      for (int h = 0; h < hlen; h++) begin
        @(negedge vga_clock);
        if (v == rst_v && h == rst_h) begin
          pre_lock = 32'(a_locked);
          resetn   = 1'b0;
          #1;
          s_addr = 32'(a_wr_address); s_col = 32'(a_wr_colour); s_en = 32'(a_wr_en);
          s_lock = 32'(a_locked); s_err = 32'(a_sync_error); s_fd = 32'(a_frame_done);
          s_ht = 32'(a_h_total); s_vt = 32'(a_v_total);
          s_b_en = 32'(b_wr_en); s_b_lock = 32'(b_locked);
        end
        if (v == rst_v && h == rst_h + 3) begin
          resetn     = 1'b1;
          rst_base_a = a_wr_total;
          rst_base_b = b_wr_total;
        end
        VGA_BLANK = (h < H_ACT) && (v < V_ACT);
        VGA_HS    = !(h >= 18 && h < 21);
        VGA_VS    = (v != 9);
        VGA_R     = h[1] ? 10'h1FF : 10'h3FF;
        VGA_G     = v[1] ? 10'h200 : 10'h000;
        VGA_B     = h[2] ? 10'h17F : 10'h3FF;
      end
    end
  endtask

  task automatic frame_start();
    base_a   = a_wr_total;
    base_b   = b_wr_total;
    base_fd  = a_fd;
    base_err = a_err;
  endtask

  initial begin
    repeat (3) @(negedge vga_clock);
    check("rst_wr_address", 32'(a_wr_address), 32'd0);
    check("rst_wr_colour",  32'(a_wr_colour),  32'd0);
    check("rst_wr_en",      32'(a_wr_en),      32'd0);
    check("rst_locked",     32'(a_locked),     32'd0);
    check("rst_sync_error", 32'(a_sync_error), 32'd0);
    check("rst_frame_done", 32'(a_frame_done), 32'd0);
    check("rst_h_total",    32'(a_h_total),    32'd0);
    check("rst_v_total",    32'(a_v_total),    32'd0);
    check("rst_b_wr_address", 32'(b_wr_address), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge vga_clock);

    // Frame 0: first VS fall only starts the measurement.
    frame_start();
    drive_frame(-1, -1, -1);
    check("f0_locked", 32'(a_locked), 32'd0);
    check("f0_writes", 32'(a_wr_total - base_a), 32'd0);

    // Frame 1: second VS fall locks.
    frame_start();
    drive_frame(-1, -1, -1);
    check("f1_locked",   32'(a_locked), 32'd1);
    check("f1_b_locked", 32'(b_locked), 32'd1);
    check("f1_h_total",  32'(a_h_total), 32'd24);
    check("f1_v_total",  32'(a_v_total), 32'd12);
    check("f1_writes",   32'(a_wr_total - base_a), 32'd0);
    check("f1_frame_done", 32'(a_fd - base_fd), 32'd0);
    check("f1_sync_error", 32'(a_err), 32'd0);

    // Frame 2: full locked frame, every dot checked.
    frame_start();
    drive_frame(-1, -1, -1);
    check("f2_writes",     32'(a_wr_total - base_a), 32'd32);
    check("f2_frame_done", 32'(a_fd - base_fd), 32'd1);
    check("f2_sync_error", 32'(a_err), 32'd0);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        check($sformatf("f2_addr_x%0d_y%0d", x, y),
              32'(a_addr_log[base_a + y * 8 + x]), 32'(y * 320 + x));
        check($sformatf("f2_colour_x%0d_y%0d", x, y),
              32'(a_col_log[base_a + y * 8 + x]), 32'(exp_colour(2 * x, 2 * y)));
      end
    end
    check("f2_b_writes", 32'(b_wr_total - base_b), 32'd8);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        check($sformatf("f2_b_addr_x%0d_y%0d", x, y),
              32'(b_addr_log[base_b + y * 4 + x]), 32'(y * 160 + x));
      end
    end

    // Frame 3: line 10 (vertical blanking) stretched to 25 cycles.
    frame_start();
    drive_frame(10, -1, -1);
    check("f3_h_total",    32'(a_h_total), 32'd25);
    check("f3_sync_error", 32'(a_err - base_err), 32'd1);
    check("f3_locked",     32'(a_locked), 32'd0);
    check("f3_b_locked",   32'(b_locked), 32'd0);
    check("f3_writes",     32'(a_wr_total - base_a), 32'd32);

    // Frame 4: partial window discarded, new measurement armed.
    frame_start();
    drive_frame(-1, -1, -1);
    check("f4_writes",  32'(a_wr_total - base_a), 32'd0);
    check("f4_locked",  32'(a_locked), 32'd0);
    check("f4_h_total", 32'(a_h_total), 32'd24);

    // Frame 5: clean full frame relocks at its end.
    frame_start();
    drive_frame(-1, -1, -1);
    check("f5_writes",     32'(a_wr_total - base_a), 32'd0);
    check("f5_locked",     32'(a_locked), 32'd1);
    check("f5_frame_done", 32'(a_fd - base_fd), 32'd0);

    frame_start();
    drive_frame(-1, -1, -1);
    check("f6_writes",     32'(a_wr_total - base_a), 32'd32);
    check("f6_b_writes",   32'(b_wr_total - base_b), 32'd8);
    check("f6_frame_done", 32'(a_fd - base_fd), 32'd1);
    check("f6_sync_error", 32'(a_err), 32'd1);

    // Frame 7: reset pulse mid-line while locked.
    frame_start();
    drive_frame(-1, 2, 5);
    check("f7_pre_locked",   pre_lock, 32'd1);
    check("f7_rst_address",  s_addr, 32'd0);
    check("f7_rst_colour",   s_col,  32'd0);
    check("f7_rst_wr_en",    s_en,   32'd0);
    check("f7_rst_locked",   s_lock, 32'd0);
    check("f7_rst_sync_err", s_err,  32'd0);
    check("f7_rst_frame_dn", s_fd,   32'd0);
    check("f7_rst_h_total",  s_ht,   32'd0);
    check("f7_rst_v_total",  s_vt,   32'd0);
    check("f7_rst_b_wr_en",  s_b_en, 32'd0);
    check("f7_rst_b_locked", s_b_lock, 32'd0);
    check("f7_writes_after_rst",   32'(a_wr_total - rst_base_a), 32'd0);
    check("f7_b_writes_after_rst", 32'(b_wr_total - rst_base_b), 32'd0);
    check("f7_locked", 32'(a_locked), 32'd0);

    frame_start();
    drive_frame(-1, -1, -1);
    check("f8_writes", 32'(a_wr_total - base_a), 32'd0);
    check("f8_locked", 32'(a_locked), 32'd1);

    frame_start();
    drive_frame(-1, -1, -1);
    check("f9_writes",      32'(a_wr_total - base_a), 32'd32);
    check("f9_first_addr",  32'(a_addr_log[base_a]), 32'd0);
    check("f9_first_col",   32'(a_col_log[base_a]), 32'd5);
    check("f9_last_addr",   32'(a_addr_log[base_a + 31]), 32'd967);
    check("f9_b_writes",    32'(b_wr_total - base_b), 32'd8);
    check("f9_b_addr_4_4",  32'(b_addr_log[base_b + 5]), 32'd161);
    check("f9_sync_error",  32'(a_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
